m_pkt_match: RTL

Inline packet-classification stage that consumes the `in_t` beat stream and produces the `out_t` beat stream. Per packet, it compares every accepted beat against a configured table of `sym_match_t` entries, keyed on word offset and 4-byte token. It tags the packet's EOP beat with the `buffer` token of the first matching entry. It sits directly downstream of ingress and upstream of host egress, and owns packet framing checks.

---
 rtl/m_pkg.sv | 40 ++++
 rtl/m_skid_buffer.sv | 50 +++++
 rtl/m_pkt_match.sv | 100 ++++++++++
 3 files changed

// File: rtl/m_pkg.sv
// Shared beat, match-table and classifier types for the packet path.
package m_pkg;
  localparam int DATA_W = 32;

  typedef logic [1:0] len_t;
  typedef logic [7:0] packet_word_off_t;
  typedef logic [7:0] buffer_t;

  typedef struct packed {
    logic              sop;
    logic              eop;
    len_t              length;
    logic [DATA_W-1:0] data;
  } in_t;

  typedef struct packed {
    logic              sop;
    logic              eop;
    len_t              length;
    logic [DATA_W-1:0] data;
    buffer_t           buffer;
  } out_t;

  typedef struct packed {
    logic              valid;
    packet_word_off_t  off;
    logic [DATA_W-1:0] match;
    buffer_t           buffer;
  } sym_match_t;

  typedef enum logic {IDLE, IN_PKT} m_pkt_match_state_t;

  typedef struct packed {
    logic    hit;
    buffer_t buffer;
  } m_pkt_match_latch_t;

  localparam packet_word_off_t PACKET_WORD_OFF_MAX = 8'hFF;
  localparam len_t             LEN_FULL            = 2'd3;
endpackage

// File: rtl/m_skid_buffer.sv
// Two-entry skid buffer with a registered upstream accept; entry 0 is the output head.
module m_skid_buffer #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic arst_n,
  input  logic push,
  input  T     push_data,
  output logic in_accept,
  output logic out_vld,
  output T     out_data,
  input  logic out_accept
);
  logic [1:0] cnt_q, cnt_d;
  T           ent0_q, ent0_d, ent1_q, ent1_d;
  logic       in_accept_q, in_accept_d;
  logic       pop;

  always_comb begin
    pop    = (cnt_q != 2'd0) & out_accept;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    if (pop) ent0_d = ent1_q;
    // A push lands in the slot left free after this cycle's pop.
    if (push) begin
      if (cnt_q == {1'b0, pop}) ent0_d = push_data;
      else                      ent1_d = push_data;
    end
    cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop};
    in_accept_d = (cnt_d <= 2'd1);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q       <= 2'd0;
      ent0_q      <= '0;
      ent1_q      <= '0;
      in_accept_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
      in_accept_q <= in_accept_d;
    end
  end

  assign in_accept = in_accept_q;
  assign out_vld   = (cnt_q != 2'd0);
  assign out_data  = ent0_q;
endmodule

// File: rtl/m_pkt_match.sv
// Inline packet classifier: framing FSM, word-offset match table and EOP buffer tagging.
module m_pkt_match
  import m_pkg::*;
#(
  parameter int N_MATCH = 4
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     in_vld,
  input  in_t                      in,
  output logic                     in_accept,
  output logic                     out_vld,
  output out_t                     out,
  input  logic                     out_accept,
  input  sym_match_t [N_MATCH-1:0] cfg_match,
  output logic                     err_framing
);
  m_pkt_match_state_t state_q, state_d;
  packet_word_off_t   woff_q, woff_d, cur_off;
  m_pkt_match_latch_t latch_q, latch_d, base_latch, latch_upd;
  logic               err_q, err_d;
  logic               beat_acc, fwd;
  logic               hit_any;
  buffer_t            hit_buf;
  out_t               beat_out;

  // woff_q holds the offset the next non-sop beat will carry.
  assign cur_off = in.sop ? '0 : woff_q;

  always_comb begin
    hit_any = 1'b0;
    hit_buf = '0;
    // Scan high to low so the lowest hitting index is left standing.
    for (int i = N_MATCH - 1; i >= 0; i--) begin
      if (cfg_match[i].valid && (cfg_match[i].off == cur_off) &&
          (in.length == LEN_FULL) && (cfg_match[i].match == in.data)) begin
        hit_any = 1'b1;
        hit_buf = cfg_match[i].buffer;
      end
    end
  end

  always_comb begin
    beat_acc   = in_vld & in_accept;
    fwd        = beat_acc & (in.sop | (state_q == IN_PKT));
    base_latch = in.sop ? '0 : latch_q;
    latch_upd  = base_latch;
    if (!base_latch.hit && hit_any) begin
      latch_upd.hit    = 1'b1;
      latch_upd.buffer = hit_buf;
    end

    beat_out.sop    = in.sop;
    beat_out.eop    = in.eop;
    beat_out.length = in.length;
    beat_out.data   = in.data;
    beat_out.buffer = (in.eop && latch_upd.hit) ? latch_upd.buffer : '0;

    state_d = state_q;
    woff_d  = woff_q;
    latch_d = latch_q;
    err_d   = err_q;
    if (beat_acc) begin
      if ((state_q == IDLE) && !in.sop)  err_d = 1'b1;
      if ((state_q == IN_PKT) && in.sop) err_d = 1'b1;
      if (fwd) begin
        state_d = in.eop ? IDLE : IN_PKT;
        woff_d  = (cur_off == PACKET_WORD_OFF_MAX) ? PACKET_WORD_OFF_MAX : cur_off + 8'd1;
        latch_d = latch_upd;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      woff_q  <= '0;
      latch_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      woff_q  <= woff_d;
      latch_q <= latch_d;
      err_q   <= err_d;
    end
  end

  assign err_framing = err_q;

  m_skid_buffer #(.T(out_t)) u_skid (
    .clk        (clk),
    .arst_n     (arst_n),
    .push       (fwd),
    .push_data  (beat_out),
    .in_accept  (in_accept),
    .out_vld    (out_vld),
    .out_data   (out),
    .out_accept (out_accept)
  );
endmodule
